// File: rtl/stream_xor_cipher_if.sv
// -----------------------------------------------------------------------------
// stream_xor_cipher_if / stream_xor_key_if
//
// Purpose:
//   Handshake bundles used by stream_xor_cipher.
//   - stream_xor_cipher_if : AXI-Stream payload with frame markers (payload in,
//                            result out).
//   - stream_xor_key_if    : AXI-Stream keystream words (no frame markers).
//
// Signals:
//   tvalid  producer -> consumer  word valid
//   tready  consumer -> producer  word accepted when tvalid & tready
//   tdata   producer -> consumer  DATA_W-bit word
//   sof/eof producer -> consumer  first/last word of a frame (payload only)
//
// Modports: master = producer side, slave = consumer side.
// -----------------------------------------------------------------------------
interface stream_xor_cipher_if #(
    parameter int DATA_W = 32
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              sof;
    logic              eof;

    modport master (output tvalid, output tdata, output sof, output eof, input tready);
    modport slave  (input tvalid, input tdata, input sof, input eof, output tready);
endinterface

interface stream_xor_key_if #(
    parameter int DATA_W = 32
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/stream_xor_cipher.sv
// -----------------------------------------------------------------------------
// stream_xor_cipher
//
// Purpose:
//   XORs an AXI-Stream payload with a keystream word stream and forwards the
//   result through a 2-entry output buffer with full backpressure. A frame can
//   be passed through unmodified (bypass, chosen on its SOF beat). Frame
//   markers travel with the data; malformed framing raises a sticky flag.
//
// Ports:
//   i_aclk         sole clock
//   i_reset        synchronous, active-high reset
//   i_enable       accept new input words while high
//   i_bypass       bypass select, sampled on accepted SOF beats only
//   s_axis         payload input  (slave)
//   k_axis         keystream input (slave)
//   m_axis         result output  (master)
//   o_err_framing  sticky framing error, cleared only by reset
//   o_frame_cnt    accepted EOF beats   (only with STREAM_XOR_STAT_EN)
//   o_word_cnt     accepted beats       (only with STREAM_XOR_STAT_EN)
//
// Build option:
//   STREAM_XOR_STAT_EN  adds the two 32-bit wrapping statistics counters.
// -----------------------------------------------------------------------------
module stream_xor_cipher #(
    parameter int DATA_W = 32
) (
    input  logic                  i_aclk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_bypass,
    stream_xor_cipher_if.slave    s_axis,
    stream_xor_key_if.slave       k_axis,
    stream_xor_cipher_if.master   m_axis,
    output logic                  o_err_framing
`ifdef STREAM_XOR_STAT_EN
    ,
    output logic [31:0]           o_frame_cnt,
    output logic [31:0]           o_word_cnt
`endif
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FRAME = 1'b1;

    typedef struct packed {
        logic              sof;
        logic              eof;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [0:0] state_q, state_d;
    logic       bypass_q, bypass_d;
    logic       err_q, err_d;

    entry_t     fifo_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] cnt_q;

    logic       bypass_eff;
    logic       has_room;
    logic       acc;
    logic       pop;
    entry_t     push_entry;

    // A SOF beat on the bus selects its own frame's bypass mode immediately;
    // every other beat follows the mode latched at the last accepted SOF.
    assign bypass_eff = (s_axis.tvalid & s_axis.sof) ? i_bypass : bypass_q;
    assign has_room   = (cnt_q != 2'd2);

    // Readies are held low during reset so no beat can slip in on that edge.
    assign s_axis.tready = ~i_reset & i_enable & has_room & (bypass_eff | k_axis.tvalid);
    assign k_axis.tready = ~i_reset & i_enable & has_room & ~bypass_eff & s_axis.tvalid;

    assign acc = s_axis.tvalid & s_axis.tready;
    assign pop = m_axis.tvalid & m_axis.tready;

    assign m_axis.tvalid = (cnt_q != 2'd0);
    assign m_axis.tdata  = fifo_q[rd_ptr_q].data;
    assign m_axis.sof    = fifo_q[rd_ptr_q].sof;
    assign m_axis.eof    = fifo_q[rd_ptr_q].eof;
    assign o_err_framing = err_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        bypass_d   = bypass_q;
        err_d      = err_q;
        push_entry = '{sof:  s_axis.sof,
                       eof:  s_axis.eof,
                       data: bypass_eff ? s_axis.tdata : (s_axis.tdata ^ k_axis.tdata)};

        if (acc) begin
            if (s_axis.sof) begin
                bypass_d = i_bypass;
            end
            // Error when SOF arrives inside a frame, or a non-SOF beat
            // arrives between frames: both collapse to sof == in_frame.
            if (s_axis.sof == (state_q == ST_FRAME)) begin
                err_d = 1'b1;
            end
            // SOF=EOF=1 is a complete frame, so EOF always returns to IDLE.
            state_d = s_axis.eof ? ST_IDLE : ST_FRAME;
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            bypass_q <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            // NOTE: the buffer entries are reset because they drive
            // m_axis_tdata/sof/eof directly and those must read 0 after reset.
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            bypass_q <= bypass_d;
            err_q    <= err_d;
            if (acc) begin
                fifo_q[wr_ptr_q] <= push_entry;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (acc & ~pop) begin
                cnt_q <= cnt_q + 2'd1;
            end else if (~acc & pop) begin
                cnt_q <= cnt_q - 2'd1;
            end
        end
    end

`ifdef STREAM_XOR_STAT_EN
    logic [31:0] frame_cnt_q;
    logic [31:0] word_cnt_q;

    // Both counters wrap naturally from 0xFFFFFFFF to 0.
    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            frame_cnt_q <= 32'd0;
            word_cnt_q  <= 32'd0;
        end else if (acc) begin
            word_cnt_q <= word_cnt_q + 32'd1;
            if (s_axis.eof) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
        end
    end

    assign o_frame_cnt = frame_cnt_q;
    assign o_word_cnt  = word_cnt_q;
`endif

endmodule

// File: tb/tb_stream_xor_cipher.sv
// -----------------------------------------------------------------------------
// tb_stream_xor_cipher
//
// Self-checking bench for stream_xor_cipher (DATA_W = 32). A queue-based model
// tracks the expected output stream, readies and framing flag every cycle;
// directed scenarios add literal expectations for key results.
// -----------------------------------------------------------------------------
module tb_stream_xor_cipher;

    localparam int DW = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          eof;
    } beat_t;

    logic clk = 1'b0;
    logic i_reset;
    logic i_enable;
    logic i_bypass;
    logic o_err_framing;
`ifdef STREAM_XOR_STAT_EN
    logic [31:0] o_frame_cnt;
    logic [31:0] o_word_cnt;
`endif

    stream_xor_cipher_if #(.DATA_W(DW)) s_if ();
    stream_xor_key_if    #(.DATA_W(DW)) k_if ();
    stream_xor_cipher_if #(.DATA_W(DW)) m_if ();

    stream_xor_cipher #(.DATA_W(DW)) dut (
        .i_aclk        (clk),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_bypass      (i_bypass),
        .s_axis        (s_if),
        .k_axis        (k_if),
        .m_axis        (m_if),
        .o_err_framing (o_err_framing)
`ifdef STREAM_XOR_STAT_EN
        ,
        .o_frame_cnt   (o_frame_cnt),
        .o_word_cnt    (o_word_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    beat_t         payload_q [$];
    logic [DW-1:0] key_q     [$];
    beat_t         exp_q     [$];
    beat_t         out_log   [$];
    int            out_cyc   [$];
    int            acc_cyc   [$];

    logic s_fire = 1'b0;
    logic k_fire = 1'b0;

    // model state
    bit in_frame    = 1'b0;
    bit byp_lat     = 1'b0;
    bit err_m       = 1'b0;
    bit rst_pending = 1'b0;

    beat_t mb;
    logic  m_eff, m_es, m_ek, m_acc, m_pop;

    logic [DW-1:0] bp_key [5] = '{32'h11111111, 32'h22222222, 32'h33333333,
                                  32'h44444444, 32'h55555555};
    logic [DW-1:0] bp_exp [5] = '{32'hB1111111, 32'h82222223, 32'h93333331,
                                  32'hE4444447, 32'hF5555551};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic beat_t out_at(input int i);
        if (i < out_log.size()) return out_log[i];
        return '1;
    endfunction

    function automatic int ocyc_at(input int i);
        if (i < out_cyc.size()) return out_cyc[i];
        return -1000;
    endfunction

    function automatic int acyc_at(input int i);
        if (i < acc_cyc.size()) return acc_cyc[i];
        return 1000;
    endfunction

    always @(posedge clk) cyc++;

    // Source driver: presents the heads of the payload/key queues, advancing
    // each one after it was handshaken on the previous edge.
    always @(posedge clk) begin
        #1;
        if (s_fire && payload_q.size() > 0) payload_q.delete(0);
        if (k_fire && key_q.size() > 0) key_q.delete(0);
        if (payload_q.size() > 0) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = payload_q[0].data;
            s_if.sof    = payload_q[0].sof;
            s_if.eof    = payload_q[0].eof;
        end else begin
            s_if.tvalid = 1'b0;
            s_if.tdata  = '0;
            s_if.sof    = 1'b0;
            s_if.eof    = 1'b0;
        end
        if (key_q.size() > 0) begin
            k_if.tvalid = 1'b1;
            k_if.tdata  = key_q[0];
        end else begin
            k_if.tvalid = 1'b0;
            k_if.tdata  = '0;
        end
    end

    // Model and compare process: at each falling edge compare the DUT with
    // the model, then advance the model by what the next rising edge does.
    always @(negedge clk) begin
        if (i_reset) begin
            check("reset_s_tready", s_if.tready, 1'b0);
            check("reset_k_tready", k_if.tready, 1'b0);
            exp_q.delete();
            in_frame    = 1'b0;
            byp_lat     = 1'b0;
            err_m       = 1'b0;
            s_fire      = 1'b0;
            k_fire      = 1'b0;
            rst_pending = 1'b1;
        end else begin
            check("m_tvalid", m_if.tvalid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check("m_tdata", m_if.tdata, exp_q[0].data);
                check("m_sof", m_if.sof, exp_q[0].sof);
                check("m_eof", m_if.eof, exp_q[0].eof);
            end else if (rst_pending) begin
                check("reset_m_tdata", m_if.tdata, '0);
                check("reset_m_markers", {m_if.sof, m_if.eof}, 2'b00);
            end
            rst_pending = 1'b0;
            check("err_framing", o_err_framing, err_m);

            m_eff = (s_if.tvalid && s_if.sof) ? i_bypass : byp_lat;
            m_es  = i_enable && (exp_q.size() < 2) && (m_eff || k_if.tvalid);
            m_ek  = i_enable && (exp_q.size() < 2) && !m_eff && s_if.tvalid;
            check("s_tready", s_if.tready, m_es);
            check("k_tready", k_if.tready, m_ek);

            m_acc  = s_if.tvalid && m_es;
            m_pop  = (exp_q.size() != 0) && m_if.tready;
            s_fire = s_if.tvalid & s_if.tready;
            k_fire = k_if.tvalid & k_if.tready;

            if (m_if.tvalid && m_if.tready) begin
                out_log.push_back('{data: m_if.tdata, sof: m_if.sof, eof: m_if.eof});
                out_cyc.push_back(cyc);
            end
            if (m_pop) exp_q.delete(0);
            if (m_acc) begin
                mb.data = m_eff ? s_if.tdata : (s_if.tdata ^ k_if.tdata);
                mb.sof  = s_if.sof;
                mb.eof  = s_if.eof;
                exp_q.push_back(mb);
                acc_cyc.push_back(cyc);
                if (s_if.sof ? in_frame : !in_frame) err_m = 1'b1;
                if (s_if.sof) byp_lat = i_bypass;
                in_frame = !s_if.eof;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic wait_out(input int n, input int budget, input string name);
        int k = 0;
        while (out_log.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check({name, "_timeout"}, out_log.size() >= n, 1'b1);
    endtask

    task automatic clear_logs();
        out_log.delete();
        out_cyc.delete();
        acc_cyc.delete();
    endtask

    task automatic push_beat(input logic [DW-1:0] d, input logic sof, input logic eof);
        payload_q.push_back('{data: d, sof: sof, eof: eof});
    endtask

    initial begin
        int k;
        i_reset     = 1'b1;
        i_enable    = 1'b1;
        i_bypass    = 1'b0;
        m_if.tready = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.sof    = 1'b0;
        s_if.eof    = 1'b0;
        k_if.tvalid = 1'b0;
        k_if.tdata  = '0;

        // Reset state
        tick(3);
        i_reset = 1'b0;
        tick(1);
        check("rst_m_tvalid", m_if.tvalid, 1'b0);
        check("rst_m_tdata", m_if.tdata, 32'h0);
        check("rst_err", o_err_framing, 1'b0);

        // Basic XOR, single-beat frame
        clear_logs();
        key_q.push_back(32'hFFFF0000);
        push_beat(32'h12345678, 1'b1, 1'b1);
        wait_out(1, 10, "basic");
        check("basic_data", out_at(0).data, 32'hEDCB5678);
        check("basic_markers", {out_at(0).sof, out_at(0).eof}, 2'b11);
        check("basic_key_used_once", key_q.size(), 0);
        check("basic_latency", ocyc_at(0) - acyc_at(0), 1);

        // Backpressure: 5 beats offered, only 2 buffered
        clear_logs();
        m_if.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            key_q.push_back(bp_key[i]);
            push_beat(32'hA0000000 + i, i == 0, i == 4);
        end
        tick(8);
        check("bp_accepted", 5 - payload_q.size(), 2);
        check("bp_s_tready_low", s_if.tready, 1'b0);
        check("bp_no_output", out_log.size(), 0);
        m_if.tready = 1'b1;
        wait_out(5, 20, "bp");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_data%0d", i), out_at(i).data, bp_exp[i]);
        end
        check("bp_one_per_cycle", ocyc_at(4) - ocyc_at(0), 4);

        // Bypass latched at SOF, toggled mid-frame
        clear_logs();
        i_bypass = 1'b1;
        key_q.push_back(32'h0F0F0F0F);
        for (int i = 0; i < 4; i++) push_beat(32'hB0000000 + i, i == 0, i == 3);
        k = 0;
        while (payload_q.size() > 3 && k < 20) begin
            tick(1);
            k++;
        end
        check("byp_sof_accepted", payload_q.size(), 3);
        i_bypass = 1'b0;
        wait_out(4, 20, "byp");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("byp_data%0d", i), out_at(i).data, 32'hB0000000 + i);
        end
        check("byp_key_untouched", key_q.size(), 1);
        push_beat(32'hC3C3C3C3, 1'b1, 1'b1);
        wait_out(5, 20, "byp_next");
        check("byp_next_xored", out_at(4).data, 32'hCCCCCCCC);
        check("byp_next_key_used", key_q.size(), 0);

        // Key starvation
        clear_logs();
        for (int i = 0; i < 3; i++) push_beat(32'hD0000000 + i, i == 0, i == 2);
        tick(10);
        check("starve_nothing_accepted", payload_q.size(), 3);
        check("starve_no_output", out_log.size(), 0);
        key_q.push_back(32'h01010101);
        key_q.push_back(32'h02020202);
        key_q.push_back(32'h03030303);
        wait_out(3, 20, "starve");
        check("starve_data0", out_at(0).data, 32'hD1010101);
        check("starve_data1", out_at(1).data, 32'hD2020203);
        check("starve_data2", out_at(2).data, 32'hD3030301);

        // Framing error: SOF, word, SOF
        clear_logs();
        check("frm_err_clear_before", o_err_framing, 1'b0);
        for (int i = 0; i < 4; i++) key_q.push_back(32'h0);
        push_beat(32'hE0, 1'b1, 1'b0);
        push_beat(32'hE1, 1'b0, 1'b0);
        push_beat(32'hE2, 1'b1, 1'b1);
        wait_out(3, 20, "frm");
        tick(1);
        check("frm_err_set", o_err_framing, 1'b1);
        check("frm_beat_forwarded", out_at(2).data, 32'hE2);
        push_beat(32'hE3, 1'b1, 1'b1);
        wait_out(4, 20, "frm_next");
        tick(3);
        check("frm_err_sticky", o_err_framing, 1'b1);

        // Reset with a full buffer
        clear_logs();
        m_if.tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            key_q.push_back(32'h5A5A5A5A);
            push_beat(32'hF0 + i, i == 0, i == 2);
        end
        k = 0;
        while (payload_q.size() > 1 && k < 20) begin
            tick(1);
            k++;
        end
        check("rstfull_two_buffered", payload_q.size(), 1);
        check("rstfull_s_tready_low", s_if.tready, 1'b0);
        i_reset = 1'b1;
        payload_q.delete();
        key_q.delete();
        tick(1);
        i_reset = 1'b0;
        check("rstfull_m_tvalid", m_if.tvalid, 1'b0);
        check("rstfull_err_cleared", o_err_framing, 1'b0);
        m_if.tready = 1'b1;
        tick(6);
        check("rstfull_nothing_emitted", out_log.size(), 0);

`ifdef STREAM_XOR_STAT_EN
        // Statistics counters and wrap
        clear_logs();
        check("stat_word_rst", o_word_cnt, 32'd0);
        check("stat_frame_rst", o_frame_cnt, 32'd0);
        key_q.push_back(32'h1);
        key_q.push_back(32'h2);
        push_beat(32'h10, 1'b1, 1'b0);
        push_beat(32'h11, 1'b0, 1'b1);
        wait_out(2, 20, "stat");
        check("stat_word", o_word_cnt, 32'd2);
        check("stat_frame", o_frame_cnt, 32'd1);
        dut.word_cnt_q = 32'hFFFFFFFF;
        key_q.push_back(32'h3);
        push_beat(32'h12, 1'b1, 1'b1);
        wait_out(3, 20, "stat_wrap");
        check("stat_word_wrap", o_word_cnt, 32'd0);
        check("stat_frame_after_wrap", o_frame_cnt, 32'd2);
`endif

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/stream_xor_cipher.md
# stream_xor_cipher

Parametrised keystream combiner for the receive and transmit datapaths: XORs an AXI-Stream payload with a keystream word stream (PRBS or ChaCha20 output) and emits the result with full AXI-Stream backpressure support. It replaces the single-width, non-backpressured XOR stage. It sits between the input AXI-Stream, the keystream source (`prbs` / `chacha20_stream`) and the downstream consumer. It adds per-frame bypass selection, frame-marker propagation and framing error detection.

## Interface
- `DATA_W`, 32: payload and keystream width in bits; multiple of 8, range 8..512.
- `i_aclk` in 1: sole clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_enable` in 1: accept new input words when high.
- `i_bypass` in 1: pass payload unmodified; sampled only on SOF beats.
- `s_axis_tvalid` in 1 / `s_axis_tready` out 1: payload handshake.
- `s_axis_tdata` in DATA_W / `s_axis_sof` in 1 / `s_axis_eof` in 1: payload and frame markers.
- `k_axis_tvalid` in 1 / `k_axis_tready` out 1 / `k_axis_tdata` in DATA_W: keystream handshake and data.
- `m_axis_tvalid` out 1 / `m_axis_tready` in 1: output handshake.
- `m_axis_tdata` out DATA_W / `m_axis_sof` out 1 / `m_axis_eof` out 1: output data and markers.
- `o_err_framing` out 1: sticky; cleared only by reset.
- `o_frame_cnt` out 32 / `o_word_cnt` out 32: statistics; present only with `STREAM_XOR_STAT_EN`.

## Operation
- **FSM states:** IDLE (between frames) and FRAME (after a SOF beat, until an EOF beat).
- **Effective bypass:**
  - On an accepted SOF beat: the live `i_bypass` value.
  - Otherwise: the value latched at the last SOF.
  - At reset: 0.
- **Beat acceptance (`acc`):** `s_axis_tvalid & s_axis_tready`.
  - `s_axis_tready = i_enable & (cnt<2) & (bypass_eff | k_axis_tvalid)`.
  - `k_axis_tready = i_enable & (cnt<2) & ~bypass_eff & s_axis_tvalid`.
  - The keystream is consumed only together with a payload beat.
  - No valid output depends on any ready input.
- **Output data:** `s_axis_tdata ^ k_axis_tdata`, or `s_axis_tdata` when bypassed. SOF/EOF travel alongside unchanged.
- **Output buffer:** 2-entry FIFO, occupancy `cnt` 0..2.
  - Push on `acc`; pop on `m_axis_tvalid & m_axis_tready`.
  - Push and pop in the same cycle leave `cnt` unchanged.
- **Framing errors:** `o_err_framing` sets on:
  - SOF accepted in FRAME state;
  - non-SOF beat accepted in IDLE state.
  - The beat is still forwarded.
  - A single beat with SOF=EOF=1 is a complete frame.
- **Enable drop mid-frame:** no new beats are accepted; buffered beats drain; FSM state is retained.
- **Reset mid-operation:** FIFO flushed, FSM to IDLE, all outputs to reset values. Any in-flight beat is discarded.

## Timing
- **Latency:** 1 cycle from `acc` to `m_axis_tvalid`, when the FIFO was empty.
- **Throughput:** 1 beat/cycle sustained while `m_axis_tready` stays high (steady state `cnt`=1).
- **Backpressure:** with `m_axis_tready` low, at most 2 beats are buffered. `s_axis_tready` falls in the cycle after `cnt` reaches 2.
- **AXI-Stream stability:** `m_axis_*` are held stable while `m_axis_tvalid & ~m_axis_tready`.
- **Reset values:**
  - `s_axis_tready`=0, `k_axis_tready`=0, `m_axis_tvalid`=0.
  - `m_axis_tdata`=0, `m_axis_sof`=0, `m_axis_eof`=0.
  - `o_err_framing`=0, counters=0.
- **Counter wrap:** counters wrap 0xFFFFFFFF→0.

## Configuration
- **`STREAM_XOR_STAT_EN` defined:**
  - `o_frame_cnt` increments on each accepted EOF beat.
  - `o_word_cnt` increments on each accepted beat.
- **`STREAM_XOR_STAT_EN` undefined:** both ports and their counter logic are absent. All other behaviour is identical.

## Test plan
- **Basic XOR:** DATA_W=32; payload 0x12345678 with SOF=EOF=1; key 0xFFFF0000; `m_axis_tready`=1 → 0x EDCB5678 one cycle later with SOF=EOF=1; key consumed once.
- **Backpressure:** hold `m_axis_tready`=0 and offer 5 beats → exactly 2 accepted, `s_axis_tready`=0. Release → all 5 emitted in order, no duplicates, 1/cycle.
- **Bypass latching:** `i_bypass`=1 at SOF, toggled to 0 mid-frame → whole 4-word frame passes unmodified, `k_axis_tready` stays 0. The next frame with `i_bypass`=0 is XORed.
- **Key starvation:** `k_axis_tvalid`=0 for 10 cycles with payload valid → nothing accepted, no output. Key returns → stream resumes with correct pairing.
- **Framing error:** SOF, word, SOF → `o_err_framing`=1 after the third beat and remains 1 until `i_reset`.
- **Reset with full buffer:** pulse `i_reset` 1 cycle with `cnt`=2 → `m_axis_tvalid`=0 next cycle, buffered data never emitted. With `STREAM_XOR_STAT_EN`, 2^32 beats wrap `o_word_cnt` to 0 (forced-preload test).
